btb_predictor: RTL and testbench

- Parametrised branch target buffer and direction predictor for the pipelined core.
- Supersedes the fixed single-mode BTB.
- Fetch performs a same-cycle lookup; Execute sends resolved branch outcomes back for update and mispredict detection.
- Adds configurable depth, PC width and counter width, tag matching, table flush, a registered redirect output, and saturating hit/mispredict statistics.

---
 rtl/btb_pkg.sv | 28 ++
 rtl/btb_predictor_sat_counter.sv | 42 ++++
 rtl/btb_predictor.sv | 160 ++++++++++++++++
 tb/tb_btb_predictor.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared constants and saturating-counter helpers for the branch target buffer.
package btb_pkg;

  localparam int unsigned CTR_WIDTH_DEF = 2;

  function automatic logic [31:0] ctr_inc(
    input logic [31:0] c,
    input logic [31:0] maxv
  );
    return (c >= maxv) ? maxv : c + 32'd1;
  endfunction

  function automatic logic [31:0] ctr_dec(
    input logic [31:0] c
  );
    return (c == 32'd0) ? 32'd0 : c - 32'd1;
  endfunction

  function automatic logic [31:0] ctr_weak(
    input int unsigned w
  );
    return 32'd1 << (w - 1);
  endfunction

  localparam logic [CTR_WIDTH_DEF-1:0] CTR_WEAK_TAKEN =
    CTR_WIDTH_DEF'(ctr_weak(CTR_WIDTH_DEF));

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// Saturating up/down counter with load; load has priority over inc/dec.
module sat_counter
  import btb_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] q_o
);

  localparam logic [W-1:0] MAXV = '1;

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (inc_i && !dec_i) begin
      q_d = W'(ctr_inc(32'(q_q), 32'(MAXV)));
    end else if (dec_i && !inc_i) begin
      q_d = W'(ctr_dec(32'(q_q)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/btb_predictor.sv
// Branch target buffer with per-entry direction counters, flush,
// registered mispredict redirect and saturating statistics.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   fetch_pc,
  output logic                  predict_taken,
  output logic [PC_WIDTH-1:0]   predict_target,
  input  logic                  upd_valid,
  input  logic [PC_WIDTH-1:0]   upd_pc,
  input  logic                  upd_taken,
  input  logic [PC_WIDTH-1:0]   upd_target,
  input  logic                  upd_pred_taken,
  input  logic [PC_WIDTH-1:0]   upd_pred_target,
  input  logic                  flush,
  output logic                  mispredict,
  output logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_WIDTH - IDX_W;
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK =
    CTR_WIDTH'(ctr_weak(CTR_WIDTH));
  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [PC_WIDTH-1:0] target;
  } entry_t;

  entry_t tbl_q [ENTRIES];
  entry_t tbl_d [ENTRIES];
  logic [CTR_WIDTH-1:0] ctr [ENTRIES];

  logic [IDX_W-1:0]    fidx;
  logic [TAG_W-1:0]    ftag;
  logic [IDX_W-1:0]    uidx;
  logic [TAG_W-1:0]    utag;
  logic                fetch_hit;
  logic                upd_hit;
  logic                upd_en;
  logic                mp_d;
  logic                mp_q;
  logic [PC_WIDTH-1:0] redirect_d;
  logic [PC_WIDTH-1:0] redirect_q;

  assign fidx = fetch_pc[IDX_W-1:0];
  assign ftag = fetch_pc[PC_WIDTH-1:IDX_W];
  assign uidx = upd_pc[IDX_W-1:0];
  assign utag = upd_pc[PC_WIDTH-1:IDX_W];

  // Lookup reads the pre-edge table only.
  assign fetch_hit = tbl_q[fidx].valid && (tbl_q[fidx].tag == ftag);
  assign predict_taken = fetch_hit && ctr[fidx][CTR_WIDTH-1];
  assign predict_target = predict_taken ? tbl_q[fidx].target
                                        : fetch_pc + PC_ONE;

  assign upd_hit = tbl_q[uidx].valid && (tbl_q[uidx].tag == utag);
  assign upd_en  = upd_valid && !flush;

  always_comb begin
    tbl_d = tbl_q;
    if (flush) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tbl_d[i].valid = 1'b0;
      end
    end else if (upd_valid && upd_taken) begin
      tbl_d[uidx].target = upd_target;
      if (!upd_hit) begin
        tbl_d[uidx].valid = 1'b1;
        tbl_d[uidx].tag   = utag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  for (genvar i = 0; i < int'(ENTRIES); i++) begin : g_ctr
    logic sel;
    assign sel = upd_en && (uidx == IDX_W'(i));
    sat_counter #(
      .W(CTR_WIDTH)
    ) u_ctr (
      .clk       (clk),
      .reset     (reset),
      .inc_i     (sel && upd_taken && upd_hit),
      .dec_i     (sel && !upd_taken && upd_hit),
      .load_i    (sel && upd_taken && !upd_hit),
      .load_val_i(CTR_WEAK),
      .q_o       (ctr[i])
    );
  end

  // Mispredict detection ignores flush.
  always_comb begin
    mp_d = upd_valid &&
           ((upd_pred_taken != upd_taken) ||
            (upd_taken && (upd_pred_target != upd_target)));
    redirect_d = redirect_q;
    if (mp_d) begin
      redirect_d = upd_taken ? upd_target : upd_pc + PC_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mp_q       <= 1'b0;
      redirect_q <= '0;
    end else begin
      mp_q       <= mp_d;
      redirect_q <= redirect_d;
    end
  end

  assign mispredict  = mp_q;
  assign redirect_pc = redirect_q;

  sat_counter #(
    .W(STAT_WIDTH)
  ) u_hit_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc_i     (fetch_hit),
    .dec_i     (1'b0),
    .load_i    (1'b0),
    .load_val_i('0),
    .q_o       (hit_count)
  );

  sat_counter #(
    .W(STAT_WIDTH)
  ) u_mp_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc_i     (mp_d),
    .dec_i     (1'b0),
    .load_i    (1'b0),
    .load_val_i('0),
    .q_o       (mispredict_count)
  );

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor with a behavioural reference model.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fetch_pc;
  logic        predict_taken;
  logic [15:0] predict_target;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_pred_taken;
  logic [15:0] upd_pred_target;
  logic        flush;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic [15:0] hit_count;
  logic [15:0] mispredict_count;

  always #5 clk = ~clk;

  btb_predictor dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_pc        (fetch_pc),
    .predict_taken   (predict_taken),
    .predict_target  (predict_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .flush           (flush),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .hit_count       (hit_count),
    .mispredict_count(mispredict_count)
  );

  typedef struct {
    string       tag;
    int          sig;
    logic [15:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic        m_v   [16];
  logic [11:0] m_tag [16];
  logic [15:0] m_tgt [16];
  int          m_ctr [16];
  logic        m_mp;
  logic [15:0] m_redir;
  int          m_hitc;
  int          m_mpc;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sample(input int sig);
    case (sig)
      0:       return {15'b0, predict_taken};
      1:       return predict_target;
      2:       return {15'b0, mispredict};
      3:       return redirect_pc;
      4:       return hit_count;
      default: return mispredict_count;
    endcase
  endfunction

  task automatic push(input string tag, input int sig,
                      input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, sample(e.sig), e.val);
    end
  endtask

  function automatic logic m_hit(input logic [15:0] pc);
    return m_v[pc[3:0]] && (m_tag[pc[3:0]] == pc[15:4]);
  endfunction

  task automatic push_regs(input string tag);
    push({tag, "/mp"}, 2, {15'b0, m_mp});
    push({tag, "/redir"}, 3, m_redir);
    push({tag, "/hitc"}, 4, 16'(m_hitc));
    push({tag, "/mpc"}, 5, 16'(m_mpc));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i]   = 1'b0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
      m_ctr[i] = 0;
    end
    m_mp    = 1'b0;
    m_redir = '0;
    m_hitc  = 0;
    m_mpc   = 0;
  endtask

  task automatic set_idle();
    upd_valid       = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;
    flush           = 1'b0;
  endtask

  task automatic set_upd(input logic [15:0] pc, input logic t,
                         input logic [15:0] tgt, input logic pt,
                         input logic [15:0] ptg);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = t;
    upd_target      = tgt;
    upd_pred_taken  = pt;
    upd_pred_target = ptg;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle(input string tag);
    logic       fh;
    logic       pt;
    logic       mp;
    logic       uh;
    logic [3:0] fi;
    logic [3:0] ui;
    fi = fetch_pc[3:0];
    fh = m_hit(fetch_pc);
    pt = fh && (m_ctr[fi] >= 2);
    push({tag, "/ptaken"}, 0, {15'b0, pt});
    push({tag, "/ptarget"}, 1, pt ? m_tgt[fi] : fetch_pc + 16'd1);
    #1;
    drain();
    if (fh && m_hitc < 65535) m_hitc++;
    mp = upd_valid && ((upd_pred_taken != upd_taken) ||
                       (upd_taken && upd_pred_target != upd_target));
    m_mp = mp;
    if (mp) begin
      m_redir = upd_taken ? upd_target : upd_pc + 16'd1;
      if (m_mpc < 65535) m_mpc++;
    end
    ui = upd_pc[3:0];
    uh = m_hit(upd_pc);
    if (flush) begin
      for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
    end else if (upd_valid) begin
      if (uh && upd_taken) begin
        if (m_ctr[ui] < 3) m_ctr[ui]++;
        m_tgt[ui] = upd_target;
      end else if (uh) begin
        if (m_ctr[ui] > 0) m_ctr[ui]--;
      end else if (upd_taken) begin
        m_v[ui]   = 1'b1;
        m_tag[ui] = upd_pc[15:4];
        m_tgt[ui] = upd_target;
        m_ctr[ui] = 2;
      end
    end
    push_regs(tag);
    @(posedge clk);
    #1;
    drain();
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    model_reset();
    push({tag, "/ptaken"}, 0, 16'd0);
    push({tag, "/ptarget"}, 1, fetch_pc + 16'd1);
    push_regs(tag);
    drain();
  endtask

  initial begin
    set_idle();
    fetch_pc = 16'h0040;
    reset    = 1'b1;
    #2;
    reset_check("rst");
    @(negedge clk);
    reset = 1'b0;

    cycle("idle40");
    set_upd(16'h0043, 1'b1, 16'h0100, 1'b0, 16'h0000);
    cycle("alloc43");
    set_idle();
    fetch_pc = 16'h0043;
    cycle("hit43");
    set_upd(16'h0043, 1'b0, 16'h0000, 1'b1, 16'h0100);
    cycle("nt1");
    cycle("nt2");
    set_idle();
    cycle("nt_chk");
    for (int i = 0; i < 4; i++) begin
      set_upd(16'h0043, 1'b1, 16'h0100, 1'b0, 16'h0000);
      cycle($sformatf("tk%0d", i));
    end
    set_upd(16'h0043, 1'b0, 16'h0000, 1'b1, 16'h0100);
    cycle("sat_nt");
    set_idle();
    cycle("sat_chk");

    fetch_pc = 16'h0053;
    cycle("alias_miss");
    set_upd(16'h0053, 1'b1, 16'h0300, 1'b0, 16'h0000);
    cycle("alias_alloc");
    set_idle();
    fetch_pc = 16'h0043;
    cycle("alias_evict");
    fetch_pc = 16'h0053;
    cycle("alias_hit");

    set_upd(16'h0022, 1'b1, 16'h0100, 1'b1, 16'h0200);
    cycle("bad_tgt");
    set_upd(16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0050);
    cycle("bad_dir");
    set_upd(16'h0053, 1'b1, 16'h0300, 1'b1, 16'h0300);
    cycle("good");

    set_upd(16'h0005, 1'b1, 16'h0555, 1'b0, 16'h0000);
    fetch_pc = 16'h0005;
    cycle("same_cyc");
    set_idle();
    cycle("next_cyc");

    set_upd(16'h0007, 1'b1, 16'h0400, 1'b0, 16'h0000);
    flush    = 1'b1;
    fetch_pc = 16'h0053;
    cycle("flush");
    set_idle();
    cycle("flush_53");
    fetch_pc = 16'h0007;
    cycle("flush_07");
    fetch_pc = 16'h0005;
    cycle("flush_05");

    set_upd(16'h0043, 1'b1, 16'h0100, 1'b0, 16'h0000);
    cycle("realloc");
    set_idle();
    fetch_pc = 16'h0043;
    cycle("pre_rst");

    for (int i = 0; i < 80; i++) begin
      fetch_pc = 16'($urandom_range(0, 2)) << 4 | 16'($urandom_range(0, 7));
      upd_valid       = 1'($urandom_range(0, 1));
      upd_pc          = 16'($urandom_range(0, 2)) << 4 |
                        16'($urandom_range(0, 7));
      upd_taken       = 1'($urandom_range(0, 1));
      upd_target      = 16'($urandom_range(0, 3)) << 8;
      upd_pred_taken  = 1'($urandom_range(0, 1));
      upd_pred_target = 16'($urandom_range(0, 3)) << 8;
      flush           = ($urandom_range(0, 15) == 0);
      cycle($sformatf("rnd%0d", i));
    end

    set_idle();
    set_upd(16'h0043, 1'b1, 16'h0100, 1'b0, 16'h0000);
    cycle("alloc_mid");
    set_idle();
    fetch_pc = 16'h0043;
    reset = 1'b1;
    #1;
    reset_check("async_rst");
    @(negedge clk);
    reset = 1'b0;
    cycle("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
